// File: rtl/lcd_frame_arbiter_if.sv
// Client, status and byte-stream signals between the LCD frame arbiter and its
// two display clients plus the downstream byte-write engine.
interface lcd_frame_arbiter_if;
    logic        a_req;
    logic [31:0] a_line1;
    logic [31:0] a_line2;
    logic        a_gnt;
    logic        b_req;
    logic [31:0] b_line1;
    logic [31:0] b_line2;
    logic        b_gnt;
    logic        wr_valid;
    logic        wr_rs;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        init_done;
    logic        owner;
    logic        frame_done;

    modport master (
        input  a_req, a_line1, a_line2, b_req, b_line1, b_line2, wr_ready,
        output a_gnt, b_gnt, wr_valid, wr_rs, wr_data, init_done, owner, frame_done
    );

    modport slave (
        output a_req, a_line1, a_line2, b_req, b_line1, b_line2, wr_ready,
        input  a_gnt, b_gnt, wr_valid, wr_rs, wr_data, init_done, owner, frame_done
    );
endinterface

// File: rtl/lcd_frame_arbiter.sv
// HD44780 sequencer: power-up init, then round-robin sharing of a 2x16 LCD
// between two clients, streaming each frame as command/data bytes.
module lcd_frame_arbiter #(
    parameter int POR_CYCLES = 750000,
    parameter int CLR_CYCLES = 82000,
    parameter int GAP_CYCLES = 50000,
    parameter int CNT_W      = 20
) (
    input  logic clk,
    input  logic rst,
    lcd_frame_arbiter_if.master bus
);
    typedef enum logic [2:0] {POR_WAIT, INIT, CLR_WAIT, IDLE, GRANT, STREAM, GAP} state_t;

    localparam logic [5:0] LAST_BYTE = 6'd33;

    state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   wait_limit;
    logic         wait_done;
    logic [1:0]   init_idx;
    logic [5:0]   byte_idx;
    logic [31:0]  snap_line1, snap_line2;
    logic         owner_q, gnt_sel, init_done_q, frame_done_q;
    logic         accept, arb_sel;
    logic         wr_valid, wr_rs;
    logic [7:0]   wr_data, init_byte, stream_byte;
    logic         line2;
    logic [4:0]   pos;
    logic [2:0]   nib_k;
    logic [31:0]  line_value;
    logic [3:0]   nib;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    // Wait states end on the cycle where cnt+1 reaches the limit, so a limit of 0 still costs one cycle.
    always_comb begin
        case (state)
            POR_WAIT: wait_limit = (CNT_W+1)'(POR_CYCLES);
            CLR_WAIT: wait_limit = (CNT_W+1)'(CLR_CYCLES);
            default:  wait_limit = (CNT_W+1)'(GAP_CYCLES);
        endcase
    end
    assign wait_done = ({1'b0, cnt} + 1'b1) >= wait_limit;

    assign accept  = bus.wr_ready && (state == INIT || state == STREAM);
    assign arb_sel = (bus.a_req && bus.b_req) ? ~owner_q : bus.b_req;

    always_comb begin
        case (init_idx)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    end

    // Frame byte: position within the current line selects cmd, label or hex digit.
    assign line2      = byte_idx >= 6'd17;
    assign pos        = line2 ? 5'(byte_idx - 6'd17) : byte_idx[4:0];
    assign line_value = line2 ? snap_line2 : snap_line1;
    assign nib_k      = 3'(pos - 5'd9);
    assign nib        = 4'(line_value >> {3'd7 - nib_k, 2'b00});

    always_comb begin
        if (pos == 5'd0)      stream_byte = line2 ? 8'hC0 : 8'h80;
        else if (pos == 5'd1) stream_byte = owner_q ? 8'h42 : 8'h41;
        else if (pos == 5'd2) stream_byte = line2 ? 8'h32 : 8'h31;
        else if (pos == 5'd3) stream_byte = 8'h3A;
        else if (pos <= 5'd8) stream_byte = 8'h20;
        else                  stream_byte = hex_char(nib);
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        wr_valid   = 1'b0;
        wr_rs      = 1'b0;
        wr_data    = 8'h00;
        bus.a_gnt  = 1'b0;
        bus.b_gnt  = 1'b0;
        case (state)
            POR_WAIT: if (wait_done) state_next = INIT;
            INIT: begin
                wr_valid = 1'b1;
                wr_data  = init_byte;
                if (accept && init_idx == 2'd2)      state_next = CLR_WAIT;
                else if (accept && init_idx == 2'd3) state_next = IDLE;
            end
            CLR_WAIT: if (wait_done) state_next = INIT;
            IDLE:     if (bus.a_req || bus.b_req) state_next = GRANT;
            GRANT: begin
                bus.a_gnt  = ~gnt_sel;
                bus.b_gnt  = gnt_sel;
                state_next = STREAM;
            end
            STREAM: begin
                wr_valid = 1'b1;
                wr_rs    = (pos != 5'd0);
                wr_data  = stream_byte;
                if (accept && byte_idx == LAST_BYTE) state_next = GAP;
            end
            GAP:      if (wait_done) state_next = IDLE;
            default:  state_next = POR_WAIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= POR_WAIT;
            cnt          <= '0;
            init_idx     <= 2'd0;
            byte_idx     <= 6'd0;
            snap_line1   <= 32'h0;
            snap_line2   <= 32'h0;
            owner_q      <= 1'b1;
            gnt_sel      <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_next;
            frame_done_q <= (state == STREAM) && accept && (byte_idx == LAST_BYTE);
            if (state_next != state)
                cnt <= '0;
            else if (state == POR_WAIT || state == CLR_WAIT || state == GAP)
                cnt <= cnt + 1'b1;
            if (state == INIT && accept) begin
                init_idx <= init_idx + 2'd1;
                if (init_idx == 2'd3) init_done_q <= 1'b1;
            end
            // Owner and snapshot move together on entry to GRANT; later input changes are ignored.
            if (state == IDLE && state_next == GRANT) begin
                gnt_sel    <= arb_sel;
                owner_q    <= arb_sel;
                snap_line1 <= arb_sel ? bus.b_line1 : bus.a_line1;
                snap_line2 <= arb_sel ? bus.b_line2 : bus.a_line2;
                byte_idx   <= 6'd0;
            end else if (state == STREAM && accept) begin
                byte_idx <= byte_idx + 6'd1;
            end
        end
    end

    assign bus.wr_valid   = wr_valid;
    assign bus.wr_rs      = wr_rs;
    assign bus.wr_data    = wr_data;
    assign bus.init_done  = init_done_q;
    assign bus.owner      = owner_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// Scoreboard bench for lcd_frame_arbiter: stimulus queues expected bytes and
// grants, a negedge monitor pops and compares whatever the DUT presents.
module tb_lcd_frame_arbiter;
    localparam int POR = 10;
    localparam int CLR = 5;
    localparam int GAP = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lcd_frame_arbiter_if bus();

    lcd_frame_arbiter #(
        .POR_CYCLES(POR), .CLR_CYCLES(CLR), .GAP_CYCLES(GAP), .CNT_W(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [8:0] exp_bytes[$];
    bit         exp_gnt[$];
    int  cyc = 0, fd_count = 0, gnt_count = 0, frame_bytes = 0, last_fd = 0;
    bit  have_fd = 0, bp_en = 0;
    string hex_digits = "0123456789ABCDEF";

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_init();
        exp_bytes.push_back({1'b0, 8'h38});
        exp_bytes.push_back({1'b0, 8'h0C});
        exp_bytes.push_back({1'b0, 8'h01});
        exp_bytes.push_back({1'b0, 8'h06});
    endtask

    task automatic push_frame(input bit cl, input logic [31:0] l1, input logic [31:0] l2);
        logic [31:0] v;
        for (int ln = 0; ln < 2; ln++) begin
            v = (ln == 0) ? l1 : l2;
            exp_bytes.push_back({1'b0, (ln == 0) ? 8'h80 : 8'hC0});
            exp_bytes.push_back({1'b1, cl ? "B" : "A"});
            exp_bytes.push_back({1'b1, (ln == 0) ? "1" : "2"});
            exp_bytes.push_back({1'b1, ":"});
            for (int s = 0; s < 5; s++) exp_bytes.push_back({1'b1, 8'h20});
            for (int k = 7; k >= 0; k--) exp_bytes.push_back({1'b1, hex_digits[v[4*k +: 4]]});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_valid"},   bus.wr_valid,   0);
        check({tag, "_wr_rs"},      bus.wr_rs,      0);
        check({tag, "_wr_data"},    bus.wr_data,    0);
        check({tag, "_gnt"},        {bus.a_gnt, bus.b_gnt}, 0);
        check({tag, "_frame_done"}, bus.frame_done, 0);
        check({tag, "_init_done"},  bus.init_done,  0);
        check({tag, "_owner"},      bus.owner,      1);
    endtask

    task automatic wait_fd(input int target, input int budget, input string name);
        int n = 0;
        while (fd_count < target && n < budget) begin
            @(posedge clk); #1; n++;
        end
        check(name, fd_count >= target, 1);
    endtask

    task automatic wait_gnt(input int target, input int budget, input string name);
        int n = 0;
        while (gnt_count < target && n < budget) begin
            @(posedge clk); #1; n++;
        end
        check(name, gnt_count >= target, 1);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: scoreboard pops, stall stability, grant order and gap spacing.
    initial begin
        bit         prev_stall = 0;
        logic [8:0] prev_byte  = '0;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall  = 0;
                have_fd     = 0;
                frame_bytes = 0;
            end else begin
                if (prev_stall)
                    check("stall_hold", {bus.wr_valid, bus.wr_rs, bus.wr_data}, {1'b1, prev_byte});
                if (bus.wr_valid && bus.wr_ready) begin
                    if (exp_bytes.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_byte: got %0h, expected none", {bus.wr_rs, bus.wr_data});
                    end else begin
                        e = exp_bytes.pop_front();
                        check("wr_byte", {bus.wr_rs, bus.wr_data}, e);
                    end
                    frame_bytes++;
                end
                if (bus.a_gnt || bus.b_gnt) begin
                    check("gnt_onehot", bus.a_gnt && bus.b_gnt, 0);
                    if (exp_gnt.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_gnt: got b_gnt=%0b, expected none", bus.b_gnt);
                    end else begin
                        check("gnt_client", bus.b_gnt, exp_gnt.pop_front());
                    end
                    check("owner_at_gnt", bus.owner, bus.b_gnt);
                    if (have_fd) check("gap_cycles", (cyc - last_fd) >= GAP + 1, 1);
                    frame_bytes = 0;
                    gnt_count++;
                end
                if (bus.frame_done) begin
                    check("frame_len", frame_bytes, 34);
                    last_fd = cyc;
                    have_fd = 1;
                    fd_count++;
                end
                prev_stall = bus.wr_valid && !bus.wr_ready;
                prev_byte  = {bus.wr_rs, bus.wr_data};
            end
        end
    end

    // Ready driver: always 1 unless backpressure is enabled, then low for stretches of up to 20 cycles.
    initial begin
        int low_left = 0;
        bus.wr_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!bp_en) begin
                bus.wr_ready = 1'b1;
                low_left = 0;
            end else if (low_left > 0) begin
                bus.wr_ready = 1'b0;
                low_left--;
            end else if ($urandom_range(0, 2) == 0) begin
                bus.wr_ready = 1'b0;
                low_left = $urandom_range(0, 19);
            end else begin
                bus.wr_ready = 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        bus.a_req = 0; bus.b_req = 0;
        bus.a_line1 = 32'h1234ABCD; bus.a_line2 = 32'hDEADBEEF;
        bus.b_line1 = 32'h0F9A5C37; bus.b_line2 = 32'h00000000;

        // Reset state and init timing.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        push_init();
        rst = 1'b1;
        for (int i = 0; i < POR; i++) begin
            @(negedge clk);
            check("por_quiet", bus.wr_valid, 0);
        end
        @(negedge clk);
        check("init_first_valid", {bus.wr_valid, bus.wr_rs, bus.wr_data}, {2'b10, 8'h38});
        repeat (2) @(negedge clk);
        for (int i = 0; i < CLR; i++) begin
            @(negedge clk);
            check("clr_quiet", bus.wr_valid, 0);
        end
        @(negedge clk);
        check("init_last_valid", {bus.wr_valid, bus.wr_data}, {1'b1, 8'h06});
        check("init_done_early", bus.init_done, 0);
        @(negedge clk);
        check("init_done", bus.init_done, 1);
        check("idle_quiet", bus.wr_valid, 0);

        // Round-robin with both clients holding requests: A, B, A, B.
        push_frame(0, 32'h1234ABCD, 32'hDEADBEEF);
        push_frame(1, 32'h0F9A5C37, 32'h00000000);
        push_frame(0, 32'h1234ABCD, 32'hDEADBEEF);
        push_frame(1, 32'h0F9A5C37, 32'h00000000);
        exp_gnt.push_back(0); exp_gnt.push_back(1);
        exp_gnt.push_back(0); exp_gnt.push_back(1);
        bus.a_req = 1; bus.b_req = 1;
        wait_fd(4, 400, "rr_frames");
        bus.a_req = 0; bus.b_req = 0;
        check("rr_bytes_left", exp_bytes.size(), 0);
        check("rr_gnts_left", exp_gnt.size(), 0);

        // Backpressure plus snapshot isolation on a single A frame.
        push_frame(0, 32'h1234ABCD, 32'hDEADBEEF);
        exp_gnt.push_back(0);
        bp_en = 1;
        t = gnt_count;
        bus.a_req = 1;
        wait_gnt(t + 1, 100, "bp_gnt");
        bus.a_line1 = 32'hFFFFFFFF;
        bus.a_req = 0;
        wait_fd(5, 1200, "bp_frame");
        bp_en = 0;
        check("bp_bytes_left", exp_bytes.size(), 0);

        // Reset at byte 12 of a frame; init replays and A wins the next grant.
        bus.a_line1 = 32'h89ABCDEF; bus.a_line2 = 32'h01234567;
        push_frame(0, 32'h89ABCDEF, 32'h01234567);
        exp_gnt.push_back(0);
        t = gnt_count;
        bus.a_req = 1;
        wait_gnt(t + 1, 100, "rst_pre_gnt");
        bus.a_req = 0;
        t = 0;
        while (frame_bytes < 12 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        check("rst_reach_byte12", frame_bytes, 12);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid");
        exp_bytes.delete();
        repeat (2) @(posedge clk);
        #1;
        push_init();
        push_frame(0, 32'h89ABCDEF, 32'h01234567);
        exp_gnt.push_back(0);
        t = gnt_count;
        bus.a_req = 1; bus.b_req = 1;
        rst = 1'b1;
        wait_gnt(t + 1, 200, "post_rst_gnt");
        bus.a_req = 0; bus.b_req = 0;
        wait_fd(6, 200, "post_rst_frame");
        check("post_rst_init_done", bus.init_done, 1);
        check("post_rst_bytes_left", exp_bytes.size(), 0);
        check("post_rst_gnts_left", exp_gnt.size(), 0);

        repeat (GAP + 4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
